// File: rtl/frame_pkg.sv
// Shared types and constants for the frame decoder: FSM states, default SYNC byte,
// and the address-width helper used to size buffer pointers from DEPTH.
package frame_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_DRAIN
    } state_e;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // A one-entry-wide address would be zero bits, so clamp to at least 1.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/frame_buffer.sv
// DEPTH x 8 payload store: synchronous write, asynchronous (combinational) read.
module frame_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (we && (waddr == AW'(gi))) begin
                    mem_q[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/frame_decode.sv
// Frame decoder: SYNC, LEN, payload, CHK; validated payload is replayed on a
// stream output. Optional inter-byte timeout is enabled by FRAME_TIMEOUT_EN.
module frame_decode
    import frame_pkg::*;
#(
    parameter int          DEPTH   = 16,
    parameter logic [7:0]  SYNC    = SYNC_DEFAULT,
    parameter int          TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_stb,
    input  logic [7:0] rx_dat,
    output logic       rx_rdy,
    output logic       out_stb,
    output logic [7:0] out_dat,
    output logic       out_last,
    input  logic       out_rdy,
    output logic       err_stb,
    output logic [7:0] err_cnt
);

    localparam int         AW      = addr_width(DEPTH);
    localparam logic [8:0] DEPTH_V = 9'(DEPTH);

    state_e     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] wr_q, wr_d;
    logic [7:0] rd_q, rd_d;
    logic [7:0] sum_q, sum_d;
    logic       err_stb_q, err_stb_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       err_event;
    logic       buf_we;
    logic       rx_acc;
    logic       out_acc;
    logic       is_last;

`ifdef FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer_q, timer_d;
    logic          timer_active;
    logic          timeout_hit;
`endif

    // Outputs are forced quiet while reset is held, not just after the edge.
    assign rx_rdy   = rst_n && (state_q != ST_DRAIN);
    assign out_stb  = rst_n && (state_q == ST_DRAIN);
    assign is_last  = (rd_q == len_q - 8'd1);
    assign out_last = out_stb && is_last;
    assign err_stb  = rst_n && err_stb_q;
    assign err_cnt  = rst_n ? err_cnt_q : 8'd0;
    assign rx_acc   = rx_stb && rx_rdy;
    assign out_acc  = out_stb && out_rdy;

    frame_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buffer (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wr_q[AW-1:0]),
        .wdata (rx_dat),
        .raddr (rd_q[AW-1:0]),
        .rdata (out_dat)
    );

`ifdef FRAME_TIMEOUT_EN
    assign timer_active = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CHK);
    assign timeout_hit  = timer_active && !rx_acc && (timer_q == TW'(TIMEOUT - 1));
    assign timer_d      = (timer_active && !rx_acc && !timeout_hit) ? timer_q + 1'b1 : '0;
`endif

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        sum_d     = sum_q;
        err_event = 1'b0;
        buf_we    = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (rx_acc && (rx_dat == SYNC)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_acc) begin
                    if ((rx_dat == 8'd0) || ({1'b0, rx_dat} > DEPTH_V)) begin
                        err_event = 1'b1;
                        state_d   = ST_HUNT;
                    end else begin
                        len_d   = rx_dat;
                        sum_d   = rx_dat;
                        wr_d    = 8'd0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx_acc) begin
                    buf_we = 1'b1;
                    sum_d  = sum_q + rx_dat;
                    wr_d   = wr_q + 8'd1;
                    if (wr_q == len_q - 8'd1) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (rx_acc) begin
                    if (8'(sum_q + rx_dat) == 8'd0) begin
                        rd_d    = 8'd0;
                        state_d = ST_DRAIN;
                    end else begin
                        err_event = 1'b1;
                        state_d   = ST_HUNT;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_acc) begin
                    rd_d = rd_q + 8'd1;
                    if (is_last) begin
                        state_d = ST_HUNT;
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase

`ifdef FRAME_TIMEOUT_EN
        if (timeout_hit) begin
            err_event = 1'b1;
            state_d   = ST_HUNT;
        end
`endif

        err_stb_d = err_event;
        err_cnt_d = (err_event && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_HUNT;
            len_q     <= 8'd0;
            wr_q      <= 8'd0;
            rd_q      <= 8'd0;
            sum_q     <= 8'd0;
            err_stb_q <= 1'b0;
            err_cnt_q <= 8'd0;
`ifdef FRAME_TIMEOUT_EN
            timer_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            sum_q     <= sum_d;
            err_stb_q <= err_stb_d;
            err_cnt_q <= err_cnt_d;
`ifdef FRAME_TIMEOUT_EN
            timer_q   <= timer_d;
`endif
        end
    end

endmodule

// File: tb/tb_frame_decode.sv
// Self-checking bench for frame_decode: directed frames plus randomized frames checked
// against a frame-level model; honours FRAME_TIMEOUT_EN for the idle-line scenario.
module tb_frame_decode;

    localparam int         DEPTH = 16;
    localparam logic [7:0] SYNC  = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_stb = 1'b0;
    logic [7:0] rx_dat = 8'h00;
    logic       rx_rdy;
    logic       out_stb;
    logic [7:0] out_dat;
    logic       out_last;
    logic       out_rdy = 1'b0;
    logic       err_stb;
    logic [7:0] err_cnt;

    int tests = 0;
    int fails = 0;

    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    int         err_pulses = 0;
    int         exp_pulses = 0;
    int         exp_err = 0;

    bit         rdy_hold = 1'b0;
    bit         rdy_rand = 1'b0;
    bit         hold_p = 1'b0;
    logic [8:0] hold_v = '0;
    bit         last_p = 1'b0;

    frame_decode #(.DEPTH(DEPTH), .SYNC(SYNC), .TIMEOUT(50000)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_stb   (rx_stb),
        .rx_dat   (rx_dat),
        .rx_rdy   (rx_rdy),
        .out_stb  (out_stb),
        .out_dat  (out_dat),
        .out_last (out_last),
        .out_rdy  (out_rdy),
        .err_stb  (err_stb),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic note_err();
        exp_pulses++;
        if (exp_err < 255) exp_err++;
    endtask

    // Consumer side: out_rdy changes just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_rdy = rdy_hold ? 1'b0 : (rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Monitor on the falling edge: collect output, count error pulses, check holds.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_rx_rdy", rx_rdy, 0);
                check("rst_out_stb", out_stb, 0);
                check("rst_out_last", out_last, 0);
                check("rst_err_stb", err_stb, 0);
                check("rst_err_cnt", err_cnt, 0);
                hold_p = 1'b0;
                last_p = 1'b0;
            end else begin
                if (hold_p) begin
                    check("hold_stb", out_stb, 1);
                    check("hold_dat", {out_last, out_dat}, hold_v);
                end
                if (last_p) check("post_drain_rdy", rx_rdy, 1);
                if (out_stb) check("drain_rx_rdy", rx_rdy, 0);
                if (err_stb) err_pulses++;
                if (out_stb && out_rdy) got_q.push_back({out_last, out_dat});
                hold_p = out_stb && !out_rdy;
                hold_v = {out_last, out_dat};
                last_p = out_stb && out_rdy && out_last;
            end
        end
    end

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rx_stb = 1'b1;
        rx_dat = b;
        while (!rx_rdy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            tests++;
            fails++;
            $display("FAIL rx_accept_timeout: rx_rdy observed 0, required 1");
        end
        @(posedge clk);
        #1 rx_stb = 1'b0;
    endtask

    // Frame-level model: validity follows directly from the LEN range and checksum rule.
    task automatic frame(input logic [7:0] len, input logic [7:0] pl[$], input int chk_in);
        int sum;
        logic [7:0] chk;
        send_byte(SYNC);
        send_byte(len);
        if (len == 0 || len > DEPTH) begin
            note_err();
            return;
        end
        sum = len;
        for (int i = 0; i < len; i++) begin
            send_byte(pl[i]);
            sum += pl[i];
        end
        chk = (chk_in < 0) ? 8'((256 - (sum % 256)) % 256) : 8'(chk_in);
        send_byte(chk);
        if (((sum + chk) % 256) == 0) begin
            for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), pl[i]});
        end else begin
            note_err();
        end
    endtask

    task automatic wait_and_compare(input string tag);
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_out_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_out_byte"}, got_q[i], exp_q[i]);
        check({tag, "_err_pulses"}, err_pulses, exp_pulses);
        check({tag, "_err_cnt"}, err_cnt, exp_err);
        $display("[TB] %s: %0d bytes, %0d errors", tag, exp_q.size(), exp_err);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] pl[$];
        int         base;
        int         n;

        // Reset
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_rx_rdy", rx_rdy, 1);
        check("idle_out_stb", out_stb, 0);

        // Basic valid frame
        pl = '{8'h11, 8'h22, 8'h33};
        frame(8'd3, pl, 8'h97);
        wait_and_compare("valid3");

        // Bad checksum
        frame(8'd3, pl, 8'h96);
        wait_and_compare("badchk");

        // Zero and oversize LEN
        pl.delete();
        frame(8'd0, pl, -1);
        @(negedge clk);
        check("len0_hunt", rx_rdy, 1);
        frame(8'h11, pl, -1);
        wait_and_compare("badlen");

        // Full-depth frame with a mid-drain stall
        pl.delete();
        for (int i = 0; i < DEPTH; i++) pl.push_back(8'($urandom));
        pl[3] = SYNC;
        base = got_q.size();
        frame(8'(DEPTH), pl, -1);
        n = 0;
        while (got_q.size() < base + 8 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        rdy_hold = 1'b1;
        repeat (5) @(posedge clk);
        rdy_hold = 1'b0;
        wait_and_compare("full_stall");

        // Randomized frames with noise and back-pressure
        rdy_rand = 1'b1;
        for (int f = 0; f < 30; f++) begin
            int r;
            int len;
            int chk;
            repeat ($urandom_range(0, 2)) begin
                logic [7:0] nb;
                nb = 8'($urandom);
                if (nb == SYNC) nb = 8'h00;
                send_byte(nb);
            end
            r = $urandom_range(0, 9);
            case (r)
                0: len = 0;
                1: len = DEPTH + 1 + $urandom_range(0, 5);
                2: len = DEPTH;
                3: len = 1;
                default: len = $urandom_range(1, DEPTH);
            endcase
            pl.delete();
            for (int i = 0; i < len && len <= DEPTH; i++)
                pl.push_back(($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom));
            chk = -1;
            if ($urandom_range(0, 4) == 0 && len >= 1 && len <= DEPTH) begin
                int s;
                s = len;
                foreach (pl[i]) s += pl[i];
                chk = ((256 - (s % 256)) % 256 + $urandom_range(1, 255)) % 256;
            end
            frame(8'(len), pl, chk);
        end
        wait_and_compare("random");
        rdy_rand = 1'b0;

        // Idle line partway through a frame
        send_byte(SYNC);
        send_byte(8'h02);
        send_byte(8'h11);
        repeat (50003) @(posedge clk);
`ifdef FRAME_TIMEOUT_EN
        note_err();
        pl = '{8'h7F};
        frame(8'd1, pl, 8'h80);
`else
        send_byte(8'h22);
        send_byte(8'hCB);
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b1, 8'h22});
`endif
        wait_and_compare("idle");

        // Reset pulse while in DATA
        send_byte(SYNC);
        send_byte(8'h05);
        send_byte(8'h01);
        send_byte(8'h02);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_err = 0;
        wait_and_compare("rst_mid");
        pl = '{8'hA5, 8'h5A};
        frame(8'd2, pl, -1);
        wait_and_compare("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_decode.md
FRAME_DECODE -- requirements
Module: frame_decode

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the maximum payload length in bytes; it is a power of two between 2 and 256.
REQ-002 Parameter SYNC, default 8'hA5, SHALL set the frame start byte.
REQ-003 Parameter TIMEOUT, default 50000, SHALL set the inter-byte timeout in clk cycles.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-006 rx_stb  input  1  SHALL flag that a received byte is valid; it is held until accepted.
REQ-007 rx_dat  input  8  SHALL carry the received byte.
REQ-008 rx_rdy  output  1  SHALL flag that the block accepts rx_dat this cycle.
REQ-009 out_stb  output  1  SHALL flag that a validated payload byte is valid on out_dat.
REQ-010 out_dat  output  8  SHALL carry the payload byte.
REQ-011 out_last  output  1  SHALL mark the final payload byte of a frame.
REQ-012 out_rdy  input  1  SHALL flag that the consumer accepts out_dat this cycle.
REQ-013 err_stb  output  1  SHALL pulse for one cycle on each discarded frame.
REQ-014 err_cnt  output  8  SHALL count discarded frames and saturate at 255.

Function
REQ-015 Frame format SHALL be: SYNC, LEN, LEN payload bytes, CHK; the frame is valid when (LEN + sum of payload + CHK) mod 256 == 0.
REQ-016 An input byte SHALL be accepted only on a cycle with rx_stb & rx_rdy; an output byte SHALL be consumed only on a cycle with out_stb & out_rdy.
REQ-017 States SHALL be HUNT, LEN, DATA, CHK and DRAIN; rx_rdy = 1 in HUNT, LEN, DATA and CHK, and rx_rdy = 0 in DRAIN.
REQ-018 HUNT: an accepted byte equal to SYNC SHALL go to LEN; any other byte SHALL be dropped silently, with no error.
REQ-019 LEN: if the byte is 0 or greater than DEPTH, the block SHALL record an error and go to HUNT; otherwise it SHALL latch the length, seed the running sum with LEN and go to DATA.
REQ-020 DATA: each byte SHALL be written to buffer[wr] and added to the sum, and wr SHALL increment; after the LEN-th byte the block SHALL go to CHK.
REQ-021 CHK: if sum + byte is 0 mod 256, the block SHALL go to DRAIN with rd = 0; otherwise it SHALL record an error, discard the buffer and go to HUNT.
REQ-022 DRAIN: out_stb SHALL be 1 from the cycle after CHK is accepted; out_dat = buffer[rd]; out_last = (rd == LEN-1).
REQ-023 DRAIN: each consume SHALL increment rd; consuming the last byte SHALL go to HUNT, and rx_rdy SHALL be 1 on the following cycle.
REQ-024 Latency: the first payload byte SHALL be on out_dat exactly 1 cycle after the CHK byte is accepted.
REQ-025 With out_rdy low, out_stb, out_dat and out_last SHALL hold stable.
REQ-026 A SYNC value inside LEN, DATA or CHK SHALL be treated as ordinary data, with no resynchronisation.
REQ-027 Recording an error SHALL mean: err_stb = 1 for exactly one cycle, and err_cnt += 1 unless it is already 255.
REQ-028 A frame with LEN == DEPTH SHALL be accepted and drained in full.

Reset
REQ-029 While rst_n = 0, the block SHALL hold: state = HUNT, rx_rdy = 0, out_stb = 0, out_last = 0, err_stb = 0, err_cnt = 0, wr = rd = 0, sum = 0, timer = 0; buffer contents are not reset.
REQ-030 Reset asserted mid-frame or mid-drain SHALL abandon the frame, with no err_stb and no further out_stb.

Configuration
REQ-031 With macro FRAME_TIMEOUT_EN defined, a timer SHALL clear on every accepted byte and count while in LEN, DATA or CHK.
REQ-032 With FRAME_TIMEOUT_EN defined, reaching TIMEOUT cycles SHALL record an error and return to HUNT.
REQ-033 With FRAME_TIMEOUT_EN defined, the timer SHALL be held at 0 in HUNT and DRAIN.
REQ-034 Without FRAME_TIMEOUT_EN, no timer logic SHALL exist, and a partial frame SHALL wait indefinitely.

Structure
REQ-035 Shared package frame_pkg SHALL hold the state encodings, the default SYNC value and the width helper for DEPTH.
REQ-036 Sub-module frame_buffer SHALL be a DEPTH x 8 register file with a synchronous write port and an asynchronous read port.
REQ-037 frame_decode SHALL instantiate frame_buffer once.

Verification
REQ-038 Input A5 03 11 22 33 97 SHALL give out bytes 11, 22, 33, with out_last only on 33 and err_cnt = 0.
REQ-039 The same frame with CHK = 96 SHALL give no out_stb, one err_stb pulse and err_cnt = 1.
REQ-040 Input A5 00, then A5 11 with DEPTH = 16, SHALL give 2 err_stb pulses, err_cnt = 2 and a return to HUNT each time.
REQ-041 A valid 16-byte frame with out_rdy low for 5 cycles mid-drain SHALL keep rx_rdy = 0 until the last byte is consumed, hold out_dat stable and deliver all 16 bytes in order.
REQ-042 With FRAME_TIMEOUT_EN, input A5 02 11 then idle for 50000 cycles SHALL give an err_stb pulse, after which A5 01 7F 80 yields 7F.
REQ-043 Without FRAME_TIMEOUT_EN, the same idle stimulus SHALL give no error and the frame SHALL complete.
REQ-044 rst_n low for 1 cycle in DATA SHALL give no output, err_cnt = 0, and the next valid frame SHALL decode correctly.
